// File: rtl/dyn_gate_sequencer.sv
// Serial stereo gate/compressor: one multiplier plus a restoring divider walk L0,R0..L15,R15.
// 26 cycles per slot (MUL, DIV_ITERS x DIV, WRITE); a full block is 832 cycles from accept to DONE.
module dyn_gate_sequencer #(
  parameter int HOLD_SAMPLES = 4,
  parameter int DIV_ITERS    = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [15:0][15:0] i_seq_l,
  input  logic [15:0][15:0] i_seq_r,
  input  logic [15:0]       threshold_gate,
  input  logic [15:0]       threshold_comp,
  input  logic [4:0]        ratio,
  input  logic [15:0]       makeup,
  output logic [15:0][15:0] o_seq_l,
  output logic [15:0][15:0] o_seq_r,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_gate_open_l,
  output logic              o_gate_open_r
);

  localparam int IW = $clog2(DIV_ITERS + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_WRITE, ST_DONE} state_e;
  typedef enum logic [1:0] {G_CLOSED, G_OPEN, G_HOLD} gate_e;

  typedef struct packed {
    gate_e      st;
    logic [7:0] cnt;
  } gate_t;

  state_e              state_q, state_d;
  logic [4:0]          slot_q, slot_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic [15:0][15:0]   in_l_q, in_l_d, in_r_q, in_r_d;
  logic [15:0][15:0]   out_l_q, out_l_d, out_r_q, out_r_d;
  logic [15:0]         thg_q, thg_d, thc_q, thc_d, mk_q, mk_d;
  logic [4:0]          rat_q, rat_d;
  logic [4:0]          div_q, div_d;
  logic [4:0]          rem_q, rem_d;
  logic [DIV_ITERS-1:0] qd_q, qd_d;
  gate_t               gate_l_q, gate_l_d, gate_r_q, gate_r_d;

  logic [15:0]          x;
  logic [31:0]          product;
  logic [DIV_ITERS-1:0] scaled;
  logic [5:0]           trial, diff;
  logic [15:0]          result;
  gate_t                gate_cur;

  function automatic gate_t gate_next(input gate_t cur, input logic above);
    gate_t nxt;
    nxt = cur;
    case (cur.st)
      G_CLOSED: if (above) nxt.st = G_OPEN;
      G_OPEN: begin
        if (!above) begin
          nxt.st  = G_HOLD;
          nxt.cnt = 8'd1;
        end
      end
      G_HOLD: begin
        if (above) begin
          nxt.st  = G_OPEN;
          nxt.cnt = 8'd0;
        end else if (cur.cnt == 8'(HOLD_SAMPLES)) begin
          nxt.st  = G_CLOSED;
          nxt.cnt = 8'd0;
        end else begin
          nxt.cnt = cur.cnt + 8'd1;
        end
      end
      default: begin
        nxt.st  = G_CLOSED;
        nxt.cnt = 8'd0;
      end
    endcase
    return nxt;
  endfunction

  // Odd slots are right channel; the sample index is the slot without its LSB.
  assign x       = slot_q[0] ? in_r_q[slot_q[4:1]] : in_l_q[slot_q[4:1]];
  assign product = 32'(x) * 32'(mk_q);
  assign scaled  = DIV_ITERS'(product >> 8);
  assign trial   = {rem_q, qd_q[DIV_ITERS-1]};
  assign diff    = trial - {1'b0, div_q};

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    iter_d   = iter_q;
    in_l_d   = in_l_q;
    in_r_d   = in_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    thg_d    = thg_q;
    thc_d    = thc_q;
    mk_d     = mk_q;
    rat_d    = rat_q;
    div_d    = div_q;
    rem_d    = rem_q;
    qd_d     = qd_q;
    gate_l_d = gate_l_q;
    gate_r_d = gate_r_q;
    gate_cur = slot_q[0] ? gate_r_q : gate_l_q;
    result   = 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          in_l_d  = i_seq_l;
          in_r_d  = i_seq_r;
          thg_d   = threshold_gate;
          thc_d   = threshold_comp;
          rat_d   = ratio;
          mk_d    = makeup;
          slot_d  = 5'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        qd_d   = scaled;
        rem_d  = 5'd0;
        iter_d = '0;
        if (x > thc_q) div_d = (rat_q == 5'd0) ? 5'd1 : rat_q;
        else           div_d = 5'd1;
        if (slot_q[0]) gate_r_d = gate_next(gate_r_q, x >= thg_q);
        else           gate_l_d = gate_next(gate_l_q, x >= thg_q);
        state_d = ST_DIV;
      end
      ST_DIV: begin
        // Quotient bits shift in from the bottom as dividend bits leave the top.
        if (trial >= {1'b0, div_q}) begin
          rem_d = diff[4:0];
          qd_d  = {qd_q[DIV_ITERS-2:0], 1'b1};
        end else begin
          rem_d = trial[4:0];
          qd_d  = {qd_q[DIV_ITERS-2:0], 1'b0};
        end
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(DIV_ITERS - 1)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (gate_cur.st == G_CLOSED)  result = 16'd0;
        else if (qd_q > DIV_ITERS'(32767)) result = 16'd32767;
        else                              result = qd_q[15:0];
        if (slot_q[0]) out_r_d[slot_q[4:1]] = result;
        else           out_l_d[slot_q[4:1]] = result;
        slot_d  = slot_q + 5'd1;
        state_d = (slot_q == 5'd31) ? ST_DONE : ST_MUL;
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      slot_q   <= 5'd0;
      iter_q   <= '0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      thg_q    <= 16'd0;
      thc_q    <= 16'd0;
      mk_q     <= 16'd0;
      rat_q    <= 5'd0;
      div_q    <= 5'd1;
      rem_q    <= 5'd0;
      qd_q     <= '0;
      gate_l_q <= '{st: G_CLOSED, cnt: 8'd0};
      gate_r_q <= '{st: G_CLOSED, cnt: 8'd0};
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      iter_q   <= iter_d;
      in_l_q   <= in_l_d;
      in_r_q   <= in_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      thg_q    <= thg_d;
      thc_q    <= thc_d;
      mk_q     <= mk_d;
      rat_q    <= rat_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      qd_q     <= qd_d;
      gate_l_q <= gate_l_d;
      gate_r_q <= gate_r_d;
    end
  end

  assign o_ready       = (state_q == ST_IDLE) && !i_rst;
  assign o_valid       = (state_q == ST_DONE) && !i_rst;
  assign o_busy        = (state_q != ST_IDLE) && !i_rst;
  assign o_seq_l       = out_l_q;
  assign o_seq_r       = out_r_q;
  assign o_gate_open_l = (gate_l_q.st != G_CLOSED);
  assign o_gate_open_r = (gate_r_q.st != G_CLOSED);

endmodule

// File: tb/tb_dyn_gate_sequencer.sv
// Scoreboard bench for dyn_gate_sequencer: expected blocks are modelled at accept time and popped at output.
module tb_dyn_gate_sequencer;

  localparam int HOLD = 4;
  localparam int BLOCK_LAT = 832;

  logic              i_clk = 1'b0;
  logic              i_rst, i_valid, i_ready;
  logic              o_ready, o_valid, o_busy, o_gate_open_l, o_gate_open_r;
  logic [15:0][15:0] i_seq_l, i_seq_r, o_seq_l, o_seq_r;
  logic [15:0]       threshold_gate, threshold_comp, makeup;
  logic [4:0]        ratio;

  always #5 i_clk = ~i_clk;

  dyn_gate_sequencer #(.HOLD_SAMPLES(HOLD), .DIV_ITERS(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_seq_l(i_seq_l), .i_seq_r(i_seq_r),
    .threshold_gate(threshold_gate), .threshold_comp(threshold_comp),
    .ratio(ratio), .makeup(makeup),
    .o_seq_l(o_seq_l), .o_seq_r(o_seq_r), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_gate_open_l(o_gate_open_l), .o_gate_open_r(o_gate_open_r)
  );

  typedef struct {
    logic [15:0][15:0] l;
    logic [15:0][15:0] r;
  } blk_t;

  blk_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gst[2];   // 0 closed, 1 open, 2 hold
  int   gcnt[2];

  task automatic model_reset();
    gst[0] = 0; gst[1] = 0; gcnt[0] = 0; gcnt[1] = 0;
  endtask

  task automatic model_sample(input int ch, input logic [15:0] xv, output logic [15:0] res);
    longint s, q;
    int     d;
    bit     above;
    above = (xv >= threshold_gate);
    if (gst[ch] == 0) begin
      if (above) gst[ch] = 1;
    end else if (gst[ch] == 1) begin
      if (!above) begin gst[ch] = 2; gcnt[ch] = 1; end
    end else begin
      if (above)                  begin gst[ch] = 1; gcnt[ch] = 0; end
      else if (gcnt[ch] == HOLD)  begin gst[ch] = 0; gcnt[ch] = 0; end
      else                        gcnt[ch] = gcnt[ch] + 1;
    end
    s = (longint'(xv) * longint'(makeup)) / 256;
    d = (xv > threshold_comp) ? ((ratio == 0) ? 1 : int'(ratio)) : 1;
    q = s / d;
    if (gst[ch] == 0)   res = 16'd0;
    else if (q > 32767) res = 16'd32767;
    else                res = 16'(q);
  endtask

  task automatic push_expected();
    blk_t e;
    logic [15:0] v;
    for (int k = 0; k < 16; k++) begin
      model_sample(0, i_seq_l[k], v); e.l[k] = v;
      model_sample(1, i_seq_r[k], v); e.r[k] = v;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents the current inputs; returns once the accept edge has passed.
  task automatic send_block(input bit keep_valid);
    int n;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 2000) begin tick(); n++; end
    n_cmp++;
    if (!o_ready) begin
      n_bad++;
      $display("FAIL accept_timeout: o_ready=%b after %0d cycles, want 1", o_ready, n);
    end
    push_expected();
    tick();
    if (!keep_valid) begin
      i_valid = 1'b0;
      threshold_gate = 16'($urandom);
      threshold_comp = 16'($urandom);
      ratio          = 5'($urandom);
      makeup         = 16'($urandom);
    end
  endtask

  // Waits for o_valid; hands off only if i_ready is already high.
  task automatic get_block(output logic [15:0][15:0] ol, output logic [15:0][15:0] orr,
                           output int lat, output bit saw_l, output bit saw_r, output int fall_l);
    int n;
    bit prev_l;
    n = 0; saw_l = o_gate_open_l; saw_r = o_gate_open_r; prev_l = o_gate_open_l; fall_l = -1;
    while (!o_valid && n < 2000) begin
      tick(); n++;
      saw_l |= o_gate_open_l;
      saw_r |= o_gate_open_r;
      if (prev_l && !o_gate_open_l && fall_l < 0) fall_l = n;
      prev_l = o_gate_open_l;
    end
    lat = n; ol = o_seq_l; orr = o_seq_r;
    if (i_ready) tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick(); tick(); tick();
    model_reset();
  endtask

  task automatic test_reset();
    i_valid = 1'b0; i_ready = 1'b1;
    do_reset();
    n_cmp++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b%b%b want 000", o_ready, o_valid, o_busy);
    end
    n_cmp++;
    if (o_seq_l !== '0 || o_seq_r !== '0 || o_gate_open_l !== 1'b0 || o_gate_open_r !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: l=%h r=%h gates=%b%b want zeros", o_seq_l, o_seq_r, o_gate_open_l, o_gate_open_r);
    end
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: o_ready=%b want 1", o_ready);
    end
  endtask

  task automatic test_unity();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    threshold_gate = 16'd100; threshold_comp = 16'd10000; ratio = 5'd4; makeup = 16'd256;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'd5000; i_seq_r[k] = 16'd20000; end
    send_block(1'b0);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== BLOCK_LAT) begin n_bad++; $display("FAIL unity_latency: got %0d want %0d", lat, BLOCK_LAT); end
    n_cmp++;
    if (ol !== e.l || ol[7] !== 16'd5000) begin n_bad++; $display("FAIL unity_l: got %h want %h", ol, e.l); end
    n_cmp++;
    if (orr !== e.r || orr[15] !== 16'd5000) begin n_bad++; $display("FAIL unity_r: got %h want %h", orr, e.r); end
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL unity_handoff: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_gate_closed();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    do_reset();
    i_rst = 1'b0;
    threshold_gate = 16'd100; threshold_comp = 16'd10000; ratio = 5'd4; makeup = 16'd256;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'd50; i_seq_r[k] = 16'd50; end
    send_block(1'b0);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (ol !== e.l || orr !== e.r || ol !== '0 || orr !== '0) begin
      n_bad++; $display("FAIL closed_data: l=%h r=%h want zeros", ol, orr);
    end
    n_cmp++;
    if (sl || sr) begin n_bad++; $display("FAIL closed_gates: saw open l=%b r=%b want 0 0", sl, sr); end
  endtask

  task automatic test_hold();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    threshold_gate = 16'd100; threshold_comp = 16'd60000; ratio = 5'd4; makeup = 16'd256;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'd50; i_seq_r[k] = 16'd300; end
    i_seq_l[0] = 16'd200;
    send_block(1'b0);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (ol !== e.l || ol[4] !== 16'd50 || ol[5] !== 16'd0) begin
      n_bad++; $display("FAIL hold_l: got %h want %h", ol, e.l);
    end
    n_cmp++;
    if (orr !== e.r) begin n_bad++; $display("FAIL hold_r: got %h want %h", orr, e.r); end
    n_cmp++;
    // L index 5 is slot 10, whose MUL edge is 26*10+1 edges after accept.
    if (fall !== 261) begin n_bad++; $display("FAIL hold_fall: gate_l fell at %0d want 261", fall); end
    n_cmp++;
    if (o_gate_open_l !== 1'b0 || o_gate_open_r !== 1'b1) begin
      n_bad++; $display("FAIL hold_gates: l=%b r=%b want 0 1", o_gate_open_l, o_gate_open_r);
    end
  endtask

  task automatic test_saturation();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    for (int pass = 0; pass < 2; pass++) begin
      threshold_gate = 16'd100; threshold_comp = 16'd10000; makeup = 16'd1024;
      ratio = (pass == 0) ? 5'd0 : 5'd31;
      for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'd20000; i_seq_r[k] = 16'd20000; end
      i_seq_r[3] = 16'd10000;
      send_block(1'b0);
      get_block(ol, orr, lat, sl, sr, fall);
      e = exp_q.pop_front();
      n_cmp++;
      if (ol !== e.l || ol[2] !== ((pass == 0) ? 16'd32767 : 16'd2580)) begin
        n_bad++; $display("FAIL sat_l%0d: got %h want %h", pass, ol, e.l);
      end
      n_cmp++;
      if (orr !== e.r || orr[3] !== 16'd32767) begin
        n_bad++; $display("FAIL sat_r%0d: got %h want %h", pass, orr, e.r);
      end
    end
  endtask

  task automatic test_zero_cases();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    threshold_gate = 16'd0; threshold_comp = 16'd100; ratio = 5'd3; makeup = 16'd0;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'(k * 1000); i_seq_r[k] = 16'(65535 - k); end
    send_block(1'b0);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (ol !== e.l || orr !== e.r || ol !== '0 || orr !== '0) begin
      n_bad++; $display("FAIL zero_makeup: l=%h r=%h want zeros", ol, orr);
    end
    n_cmp++;
    if (o_gate_open_l !== 1'b1 || o_gate_open_r !== 1'b1) begin
      n_bad++; $display("FAIL zero_gate: l=%b r=%b want 1 1", o_gate_open_l, o_gate_open_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0][15:0] ol, orr, hl, hr;
    int lat, fall;
    bit sl, sr, stable, rdy_low;
    blk_t e;
    threshold_gate = 16'd1000; threshold_comp = 16'd30000;
    ratio = 5'($urandom_range(0, 31)); makeup = 16'($urandom_range(0, 1023));
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'($urandom); i_seq_r[k] = 16'($urandom); end
    i_ready = 1'b0;
    send_block(1'b1);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (ol !== e.l || orr !== e.r) begin
      n_bad++; $display("FAIL bp_data: l=%h r=%h want %h %h", ol, orr, e.l, e.r);
    end
    hl = o_seq_l; hr = o_seq_r; stable = 1'b1; rdy_low = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (o_valid !== 1'b1 || o_seq_l !== hl || o_seq_r !== hr) stable = 1'b0;
      if (o_ready !== 1'b0) rdy_low = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL bp_stable: outputs moved, got 0 want 1"); end
    n_cmp++;
    if (!rdy_low) begin n_bad++; $display("FAIL bp_ready: o_ready rose in DONE, got 0 want 1"); end
    i_ready = 1'b1;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_handoff: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    push_expected();
    tick();
    i_valid = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL bp_reaccept: o_busy=%b want 1", o_busy); end
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== BLOCK_LAT || ol !== e.l || orr !== e.r) begin
      n_bad++; $display("FAIL bp_second: lat=%0d l=%h r=%h want %0d %h %h", lat, ol, orr, BLOCK_LAT, e.l, e.r);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0][15:0] ol, orr;
    int lat, fall;
    bit sl, sr;
    blk_t e;
    threshold_gate = 16'd10; threshold_comp = 16'd40000; ratio = 5'd2; makeup = 16'd256;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'(1000 + k); i_seq_r[k] = 16'(2000 + k); end
    send_block(1'b0);
    for (int c = 0; c < 10 * 26 + 3; c++) tick();
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: o_ready=%b want 0", o_ready); end
    tick();
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_seq_l !== '0 || o_seq_r !== '0 ||
        o_gate_open_l !== 1'b0 || o_gate_open_r !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state: busy=%b valid=%b l=%h r=%h gates=%b%b want all 0",
               o_busy, o_valid, o_seq_l, o_seq_r, o_gate_open_l, o_gate_open_r);
    end
    void'(exp_q.pop_front());
    model_reset();
    threshold_gate = 16'd10; threshold_comp = 16'd40000; ratio = 5'd2; makeup = 16'd256;
    for (int k = 0; k < 16; k++) begin i_seq_l[k] = 16'(1000 + k); i_seq_r[k] = 16'(2000 + k); end
    send_block(1'b0);
    get_block(ol, orr, lat, sl, sr, fall);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== BLOCK_LAT || ol !== e.l || orr !== e.r) begin
      n_bad++; $display("FAIL midrst_after: lat=%0d l=%h r=%h want %0d %h %h", lat, ol, orr, BLOCK_LAT, e.l, e.r);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_seq_l = '0; i_seq_r = '0;
    threshold_gate = '0; threshold_comp = '0; ratio = '0; makeup = '0;
    model_reset();
    test_reset();
    test_unity();
    test_gate_closed();
    test_hold();
    test_saturation();
    test_zero_cases();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
